// File: rtl/mips_dmem_responder.sv
// -----------------------------------------------------------------------------
// mips_dmem_responder
//
// Word-addressed data-memory responder for a simple MIPS-style load/store
// initiator. One request is accepted at a time. A request is captured in IDLE,
// waits LATENCY edges in BUSY, is committed (array write or read) on the
// BUSY->RESP edge, and its response is held in RESP until the initiator
// accepts it.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the storage array
//   LATENCY      edges from request accept to response (1..15)
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset (array is not cleared)
//   req_valid   in   initiator presents a request
//   req_ready   out  responder can accept a request (IDLE only)
//   req_write   in   1 = store word, 0 = load word
//   req_addr    in   byte address (word index = addr[31:2])
//   req_wdata   in   store data
//   resp_valid  out  response available (RESP only)
//   resp_ready  in   initiator accepts the response
//   resp_rdata  out  load data; 0 for stores and errored requests
//   resp_err    out  request was misaligned or out of range
//   busy        out  1 whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mips_dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Storage array: deliberately outside the reset domain so contents survive reset.
  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             addr_err;
  logic             commit;

  // Everything below works only on the captured request, so the initiator may
  // change its request inputs freely once the request has been accepted.
  assign idx      = addr_q[IDX_W+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) ||
                    ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
  assign commit   = (state_q == BUSY) && (cnt_q == 4'd0);

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          // Commit edge: response payload is registered here and then frozen
          // for the whole RESP phase.
          err_d   = addr_err;
          rdata_d = (addr_err || write_q) ? 32'd0 : mem[idx];
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // Returning to IDLE takes one edge; no request is accepted on it.
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array write port. Reset forces IDLE asynchronously, so an aborted request
  // can never reach the commit condition.
  always_ff @(posedge clock) begin
    if (commit && write_q && !addr_err) begin
      mem[idx] <= wdata_q;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
